// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: EXE-to-MEM request, stall and write-back bundle of data_mem_ctrl.
interface data_mem_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] alu_res;
    logic        reg_write;
    logic [3:0]  reg_addr;
    logic        hold;
    logic        wb_reg_write;
    logic [3:0]  wb_reg_addr;
    logic [15:0] wb_data;
    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, alu_res, reg_write, reg_addr,
        input  hold, wb_reg_write, wb_reg_addr, wb_data
    );
    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, alu_res, reg_write, reg_addr,
        output hold, wb_reg_write, wb_reg_addr, wb_data
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage controller, async 16-bit SRAM loads/stores with stall and registered write-back.
// Define MEM_LED_MMIO_EN to map LED_ADDR onto the led_out register instead of SRAM.
module data_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [17:0] LED_ADDR    = 18'h0BF00
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus,
    output logic [17:0]    ram_addr,
    inout  wire  [15:0]    ram_data,
    output logic           ram_en,
    output logic           ram_oe,
    output logic           ram_rw,
    output logic [15:0]    led_out
);
`ifdef MEM_LED_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic        wr_q;
    logic        lreg_write;
    logic [3:0]  lreg_addr;
    logic        mmio, mem_op, last;
    assign mmio   = MMIO && bus.mem_addr == LED_ADDR;
    assign mem_op = (bus.mem_read || bus.mem_write) && !mmio;
    assign last   = cnt == 3'(WAIT_CYCLES - 1);
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
        cnt   <= (rst || state != ACCESS) ? 3'd0 : cnt + 3'd1;
    end
    always_comb begin
        state_nx = state == IDLE   ? (mem_op ? ACCESS : IDLE) :
                   state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
    end
    // Address comes straight from EXE while accepting, so it settles a cycle before the strobes drop.
    always_comb begin
        bus.hold = !rst && (state == ACCESS || (state == IDLE && mem_op));
        ram_en   = rst || state != ACCESS;
        ram_oe   = ram_en || wr_q;
        ram_rw   = ram_en || !wr_q;
        ram_addr = rst ? 18'd0 : state == IDLE ? bus.mem_addr : addr_q;
    end
    assign ram_data = ram_rw ? 16'bz : wdata_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_reg_write <= 1'b0;
            bus.wb_reg_addr  <= '0;
            bus.wb_data      <= '0;
            led_out          <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wr_q             <= 1'b0;
            lreg_write       <= 1'b0;
            lreg_addr        <= '0;
        end else if (state == IDLE) begin
            if (mem_op) begin
                addr_q           <= bus.mem_addr;
                wdata_q          <= bus.mem_wdata;
                wr_q             <= bus.mem_write;
                lreg_write       <= bus.reg_write;
                lreg_addr        <= bus.reg_addr;
                bus.wb_reg_write <= 1'b0;
            end else if (mmio && bus.mem_write) begin
                led_out          <= bus.mem_wdata;
                bus.wb_reg_write <= 1'b0;
            end else begin
                bus.wb_reg_write <= bus.reg_write;
                bus.wb_reg_addr  <= bus.reg_addr;
                bus.wb_data      <= (mmio && bus.mem_read) ? led_out : bus.alu_res;
            end
        end else if (state == ACCESS && last) begin
            bus.wb_reg_write <= lreg_write && !wr_q;
            if (!wr_q) begin
                bus.wb_reg_addr <= lreg_addr;
                bus.wb_data     <= ram_data;
            end
        end else begin
            bus.wb_reg_write <= 1'b0;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized self-checking bench, two controllers (WAIT_CYCLES 1 and 3) on a shared SRAM model.
module tb_data_mem_ctrl;
    localparam int WC_A = 1;
    localparam int WC_B = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    data_mem_ctrl_if ifa ();
    data_mem_ctrl_if ifb ();
    wire  [15:0] bus_a, bus_b;
    logic [17:0] addr_a, addr_b;
    logic        en_a, oe_a, rw_a, en_b, oe_b, rw_b;
    logic [15:0] led_a, led_b;
    logic [15:0] sram [0:1023];
    logic [15:0] ref_mem [int];
    int total = 0;
    int bad = 0;
    int o_hold, o_en, o_rw, o_oe;
    logic [15:0] o_wbus, o_led;
    logic o_abad, o_strb;
    logic [20:0] o_dwb, o_nwb;

    data_mem_ctrl #(.WAIT_CYCLES(WC_A)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .ram_addr(addr_a), .ram_data(bus_a),
        .ram_en(en_a), .ram_oe(oe_a), .ram_rw(rw_a), .led_out(led_a)
    );
    data_mem_ctrl #(.WAIT_CYCLES(WC_B)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .ram_addr(addr_b), .ram_data(bus_b),
        .ram_en(en_b), .ram_oe(oe_b), .ram_rw(rw_b), .led_out(led_b)
    );

    // Asynchronous SRAM: drives the bus while selected and output-enabled, captures data while write-enabled.
    assign bus_a = (!en_a && !oe_a) ? sram[addr_a[9:0]] : 16'bz;
    assign bus_b = (!en_b && !oe_b) ? sram[addr_b[9:0]] : 16'bz;
    always @(posedge clk) begin
        if (!en_a && !rw_a) sram[addr_a[9:0]] <= bus_a;
        if (!en_b && !rw_b) sram[addr_b[9:0]] <= bus_b;
    end

    task automatic nop_a;
        ifa.mem_read = 1'b0; ifa.mem_write = 1'b0; ifa.mem_addr = '0; ifa.mem_wdata = '0;
        ifa.alu_res = '0; ifa.reg_write = 1'b0; ifa.reg_addr = '0;
    endtask

    task automatic nop_b;
        ifb.mem_read = 1'b0; ifb.mem_write = 1'b0; ifb.mem_addr = '0; ifb.mem_wdata = '0;
        ifb.alu_res = '0; ifb.reg_write = 1'b0; ifb.reg_addr = '0;
    endtask

    // Presents one op on A like an upstream stage that advances once hold drops; records what it saw.
    task automatic op_a(input bit rd, input bit wr, input bit rw, input logic [3:0] ra,
                        input logic [17:0] a, input logic [15:0] d, input logic [15:0] alu);
        o_hold = 0; o_en = 0; o_rw = 0; o_oe = 0; o_wbus = '0; o_abad = 1'b0; o_strb = 1'b0; o_dwb = '0;
        ifa.mem_read = rd; ifa.mem_write = wr; ifa.reg_write = rw; ifa.reg_addr = ra;
        ifa.mem_addr = a; ifa.mem_wdata = d; ifa.alu_res = alu;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!en_a) begin o_en++; if (addr_a !== a) o_abad = 1'b1; end
            if (!rw_a) begin o_rw++; o_wbus = bus_a; end
            if (!oe_a) o_oe++;
            if (!ifa.hold) begin
                o_dwb  = {ifa.wb_reg_write, ifa.wb_reg_addr, ifa.wb_data};
                o_strb = en_a & oe_a & rw_a;
                break;
            end
            o_hold++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        nop_a();
        @(negedge clk);
        o_nwb = {ifa.wb_reg_write, ifa.wb_reg_addr, ifa.wb_data};
        o_led = led_a;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if ({ifa.hold, en_a, oe_a, rw_a} !== 4'b0111) begin bad++; $display("FAIL reset_ctl_a: got %b want 0111", {ifa.hold, en_a, oe_a, rw_a}); end
        total++; if ({ifb.hold, en_b, oe_b, rw_b} !== 4'b0111) begin bad++; $display("FAIL reset_ctl_b: got %b want 0111", {ifb.hold, en_b, oe_b, rw_b}); end
        total++; if (addr_a !== 18'd0) begin bad++; $display("FAIL reset_addr_a: got %h want 0", addr_a); end
        total++; if (addr_b !== 18'd0) begin bad++; $display("FAIL reset_addr_b: got %h want 0", addr_b); end
        total++; if ({ifa.wb_reg_write, ifa.wb_reg_addr, ifa.wb_data} !== 21'd0) begin bad++; $display("FAIL reset_wb_a: got %h want 0", {ifa.wb_reg_write, ifa.wb_reg_addr, ifa.wb_data}); end
        total++; if ({ifb.wb_reg_write, ifb.wb_reg_addr, ifb.wb_data} !== 21'd0) begin bad++; $display("FAIL reset_wb_b: got %h want 0", {ifb.wb_reg_write, ifb.wb_reg_addr, ifb.wb_data}); end
        total++; if (led_a !== 16'd0) begin bad++; $display("FAIL reset_led_a: got %h want 0", led_a); end
        total++; if (led_b !== 16'd0) begin bad++; $display("FAIL reset_led_b: got %h want 0", led_b); end
        @(posedge clk); #1;
        rst = 1'b0;
        ifb.reg_write = 1'b1; ifb.reg_addr = 4'd9; ifb.alu_res = 16'hA5A5;
        @(posedge clk); #1;
        nop_b();
        ifb.mem_write = 1'b1; ifb.mem_addr = 18'h00200; ifb.mem_wdata = 16'h1111;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({ifb.hold, rw_b} !== 2'b10) begin bad++; $display("FAIL midaccess_pre: got %b want 10", {ifb.hold, rw_b}); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if ({ifb.hold, en_b, oe_b, rw_b} !== 4'b0111) begin bad++; $display("FAIL midaccess_rst_ctl: got %b want 0111", {ifb.hold, en_b, oe_b, rw_b}); end
        @(posedge clk); #1;
        rst = 1'b0;
        nop_b();
        @(negedge clk);
        total++; if ({ifb.wb_reg_write, ifb.wb_reg_addr, ifb.wb_data} !== 21'd0) begin bad++; $display("FAIL midaccess_rst_wb: got %h want 0", {ifb.wb_reg_write, ifb.wb_reg_addr, ifb.wb_data}); end
        total++; if ({ifb.hold, en_b, oe_b, rw_b} !== 4'b0111) begin bad++; $display("FAIL midaccess_post_ctl: got %b want 0111", {ifb.hold, en_b, oe_b, rw_b}); end
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough;
        logic rw; logic [3:0] ra; logic [15:0] d;
        for (int i = 0; i < 9; i++) begin
            rw = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ra = (i == 0) ? 4'd3 : 4'($urandom);
            d  = (i == 0) ? 16'h1234 : 16'($urandom);
            ifa.reg_write = rw; ifa.reg_addr = ra; ifa.alu_res = d;
            ifa.mem_addr = 18'($urandom_range(0, 1023)); ifa.mem_wdata = 16'($urandom);
            @(negedge clk);
            total++; if ({ifa.hold, en_a} !== 2'b01) begin bad++; $display("FAIL pass_hold: got %b want 01", {ifa.hold, en_a}); end
            @(posedge clk); #1;
            @(negedge clk);
            total++; if ({ifa.wb_reg_write, ifa.wb_reg_addr, ifa.wb_data} !== {rw, ra, d}) begin bad++; $display("FAIL pass_wb: got %h want %h", {ifa.wb_reg_write, ifa.wb_reg_addr, ifa.wb_data}, {rw, ra, d}); end
            @(posedge clk); #1;
        end
        nop_a();
    endtask

    task automatic test_store_load;
        op_a(1'b0, 1'b1, 1'b0, 4'd0, 18'h00100, 16'hBEEF, 16'h0);
        ref_mem[int'(18'h00100)] = 16'hBEEF;
        total++; if (o_hold !== WC_A + 1) begin bad++; $display("FAIL st_hold: got %0d want %0d", o_hold, WC_A + 1); end
        total++; if (o_rw !== WC_A) begin bad++; $display("FAIL st_rw_cycles: got %0d want %0d", o_rw, WC_A); end
        total++; if (o_wbus !== 16'hBEEF) begin bad++; $display("FAIL st_bus: got %h want beef", o_wbus); end
        total++; if ({o_strb, o_abad, o_dwb[20], o_nwb[20]} !== 4'b1000) begin bad++; $display("FAIL st_done: got %b want 1000", {o_strb, o_abad, o_dwb[20], o_nwb[20]}); end
        op_a(1'b1, 1'b0, 1'b1, 4'd5, 18'h00100, 16'h0, 16'h7777);
        total++; if ({o_hold, o_oe, o_rw} !== {WC_A + 1, WC_A, 0}) begin bad++; $display("FAIL ld_cycles: got %0d/%0d/%0d want %0d/%0d/0", o_hold, o_oe, o_rw, WC_A + 1, WC_A); end
        total++; if (o_dwb !== {1'b1, 4'd5, ref_mem[int'(18'h00100)]}) begin bad++; $display("FAIL ld_wb: got %h want %h", o_dwb, {1'b1, 4'd5, 16'hBEEF}); end
        total++; if ({o_strb, o_nwb[20]} !== 2'b10) begin bad++; $display("FAIL ld_after: got %b want 10", {o_strb, o_nwb[20]}); end
    endtask

    task automatic test_random_mem;
        logic [17:0] addrs [6]; logic [15:0] d; logic rw; logic [3:0] ra;
        for (int i = 0; i < 6; i++) begin
            addrs[i] = 18'(i * 64 + $urandom_range(0, 63));
            d = 16'($urandom);
            op_a(1'b0, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom), addrs[i], d, 16'($urandom));
            ref_mem[int'(addrs[i])] = d;
            total++; if ({o_rw, o_wbus, o_abad} !== {WC_A, d, 1'b0}) begin bad++; $display("FAIL rnd_st: got rw=%0d bus=%h abad=%b want rw=%0d bus=%h", o_rw, o_wbus, o_abad, WC_A, d); end
        end
        for (int i = 5; i >= 0; i--) begin
            rw = 1'($urandom_range(0, 1));
            ra = 4'($urandom);
            op_a(1'b1, 1'b0, rw, ra, addrs[i], 16'($urandom), 16'($urandom));
            total++; if ({o_hold, o_dwb} !== {WC_A + 1, rw, ra, ref_mem[int'(addrs[i])]}) begin bad++; $display("FAIL rnd_ld: got hold=%0d wb=%h want hold=%0d wb=%h", o_hold, o_dwb, WC_A + 1, {rw, ra, ref_mem[int'(addrs[i])]}); end
        end
    endtask

    task automatic test_both_set;
        op_a(1'b1, 1'b1, 1'b1, 4'd6, 18'h003A0, 16'hC0DE, 16'h0);
        ref_mem[int'(18'h003A0)] = 16'hC0DE;
        total++; if ({o_rw, o_oe, o_wbus} !== {WC_A, 0, 16'hC0DE}) begin bad++; $display("FAIL both_sram: got rw=%0d oe=%0d bus=%h want rw=%0d oe=0 bus=c0de", o_rw, o_oe, o_wbus, WC_A); end
        total++; if ({o_dwb[20], o_nwb[20]} !== 2'b00) begin bad++; $display("FAIL both_wb: got %b want 00", {o_dwb[20], o_nwb[20]}); end
        op_a(1'b1, 1'b0, 1'b1, 4'd2, 18'h003A0, 16'h0, 16'h0);
        total++; if (o_dwb !== {1'b1, 4'd2, ref_mem[int'(18'h003A0)]}) begin bad++; $display("FAIL both_readback: got %h want %h", o_dwb, {1'b1, 4'd2, 16'hC0DE}); end
    endtask

    task automatic test_wait3;
        int hn, on, rn; logic [20:0] dw;
        for (int k = 0; k < 2; k++) begin
            hn = 0; on = 0; rn = 0; dw = '0;
            ifb.mem_write = (k == 0); ifb.mem_read = (k == 1); ifb.reg_write = (k == 1);
            ifb.mem_addr = 18'h00321; ifb.mem_wdata = 16'h5A3C; ifb.reg_addr = 4'd12;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (!oe_b) on++;
                if (!rw_b) rn++;
                if (!ifb.hold) begin dw = {ifb.wb_reg_write, ifb.wb_reg_addr, ifb.wb_data}; break; end
                hn++;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            nop_b();
            @(posedge clk); #1;
            total++; if (hn !== WC_B + 1) begin bad++; $display("FAIL w3_hold_%0d: got %0d want %0d", k, hn, WC_B + 1); end
            total++; if ({on, rn} !== ((k == 0) ? {0, WC_B} : {WC_B, 0})) begin bad++; $display("FAIL w3_strobes_%0d: got oe=%0d rw=%0d", k, on, rn); end
            if (k == 1) begin
                total++; if (dw !== {1'b1, 4'd12, 16'h5A3C}) begin bad++; $display("FAIL w3_ld_wb: got %h want %h", dw, {1'b1, 4'd12, 16'h5A3C}); end
            end
        end
    endtask

    task automatic test_led;
`ifdef MEM_LED_MMIO_EN
        op_a(1'b0, 1'b1, 1'b0, 4'd0, 18'h0BF00, 16'h00A5, 16'h0);
        total++; if ({o_hold, o_en} !== {0, 0}) begin bad++; $display("FAIL led_st_ctl: got hold=%0d en_low=%0d want 0/0", o_hold, o_en); end
        total++; if ({o_led, o_nwb[20]} !== {16'h00A5, 1'b0}) begin bad++; $display("FAIL led_st_val: got %h want %h", {o_led, o_nwb[20]}, {16'h00A5, 1'b0}); end
        op_a(1'b1, 1'b0, 1'b1, 4'd7, 18'h0BF00, 16'h0, 16'h1111);
        total++; if ({o_hold, o_nwb} !== {0, 1'b1, 4'd7, 16'h00A5}) begin bad++; $display("FAIL led_ld: got hold=%0d wb=%h want 0 %h", o_hold, o_nwb, {1'b1, 4'd7, 16'h00A5}); end
`else
        op_a(1'b0, 1'b1, 1'b0, 4'd0, 18'h0BF00, 16'h00A5, 16'h0);
        total++; if ({o_hold, o_rw, o_led} !== {WC_A + 1, WC_A, 16'h0}) begin bad++; $display("FAIL led_off: got hold=%0d rw=%0d led=%h want %0d/%0d/0", o_hold, o_rw, o_led, WC_A + 1, WC_A); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nop_a();
        nop_b();
        test_reset();
        test_passthrough();
        test_store_load();
        test_random_mem();
        test_both_set();
        test_wait3();
        test_led();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

MEM-stage controller of the zhxpu pipeline, placed between the EXE stage (ALU result, memory controls) and the register write-back path. It performs loads and stores on the external asynchronous 16-bit SRAM (ram2) through a small state machine and passes non-memory results straight through. While an SRAM access is in flight it asserts `hold` to stall upstream stages. It presents a registered write-back triple to the register file.

## Interface
- `WAIT_CYCLES`, default 1: SRAM access-phase length in clocks; legal range 1..7.
- `LED_ADDR`, default 18'h0BF00: MMIO address of the LED register (used only with `MEM_LED_MMIO_EN`).

Ports:
- `clk` in 1: pipeline clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_read` in 1: EXE op is a load.
- `mem_write` in 1: EXE op is a store.
- `mem_addr` in 18: load/store address.
- `mem_wdata` in 16: store data.
- `alu_res` in 16: ALU result for non-load ops.
- `reg_write` in 1: EXE op writes a register.
- `reg_addr` in 4: destination register.
- `hold` out 1: stall request to stall_ctrl (combinational).
- `wb_reg_write` out 1: write-back enable (registered).
- `wb_reg_addr` out 4: write-back register.
- `wb_data` out 16: write-back value.
- `ram_addr` out 18: SRAM address.
- `ram_data` inout 16: SRAM data bus; hi-Z unless writing.
- `ram_en`, `ram_oe`, `ram_rw` out 1 each: SRAM chip enable, output enable, write enable; all active-low.
- `led_out` out 16: LED MMIO register.

## Operation
- States: IDLE, ACCESS, DONE. A 3-bit counter `cnt` counts cycles in ACCESS.
- **IDLE, no memory op:**
  - Next edge: `wb_*` <= {reg_write, reg_addr, alu_res}.
  - `hold`=0.
- **IDLE, `mem_read` or `mem_write`:**
  - `hold`=1 combinationally.
  - Latch address, wdata, reg_write, reg_addr and op type.
  - `cnt` <= 0; next state is ACCESS.
  - `wb_reg_write` <= 0 (bubble).
- **ACCESS:**
  - `ram_en`=0 and `ram_addr`=latched address.
  - Read: `ram_oe`=0, `ram_rw`=1, bus hi-Z.
  - Write: `ram_oe`=1, `ram_rw`=0, bus driven with latched wdata.
  - `hold`=1; `cnt` increments each cycle.
  - When `cnt`==WAIT_CYCLES-1: next state is DONE.
    - Read: `wb_*` <= {latched reg_write, reg_addr, ram_data}, sampled at this edge.
    - Write: `wb_reg_write` <= 0.
- **DONE:**
  - All strobes high, bus hi-Z, `hold`=0.
  - Inputs are ignored: they still show the completed op.
  - Next edge: `wb_reg_write` <= 0, next state is IDLE.
- `mem_read` and `mem_write` both set: executed as a store; the load is dropped.
- `rst`=1 in any state, including mid-ACCESS:
  - Next edge: state <= IDLE, `wb_reg_write`/`wb_reg_addr`/`wb_data` <= 0, `led_out` <= 0.
  - `hold` is forced 0 while `rst`=1.
  - Strobes are high and the bus is hi-Z from the first reset cycle.

## Timing
- Reset values: `wb_*`=0, `led_out`=0, `ram_en`/`ram_oe`/`ram_rw`=1, `ram_data` hi-Z, `ram_addr`=0, `hold`=0.
- Non-memory op: 1-cycle latency, no stall.
- Memory op accepted in cycle N:
  - `hold`=1 during cycles N..N+WAIT_CYCLES.
  - DONE occurs in cycle N+WAIT_CYCLES+1, where `hold`=0 and a load result is visible on `wb_*`.
  - Total stall is WAIT_CYCLES+1 cycles.
- Upstream must keep the EXE inputs stable while `hold`=1. The block relies only on its latched copies.
- `ram_rw` never toggles low in the same cycle as an `ram_addr` change: the address is stable for the whole ACCESS phase.
- No back-to-back SRAM accesses: there is always at least one cycle with strobes high (DONE) between them.

## Configuration
- `MEM_LED_MMIO_EN` defined:
  - Store to `LED_ADDR`: writes `led_out` at the IDLE edge. No SRAM strobes, no `hold`, `wb_reg_write` <= 0.
  - Load from `LED_ADDR`: returns `led_out` with 1-cycle latency and no `hold`.
- Undefined: `LED_ADDR` is ordinary SRAM and `led_out` is constant 0.

## Test plan
- Reset: assert `rst` mid-ACCESS of a store -> next cycle `ram_rw`=1, `ram_en`=1, bus hi-Z, `hold`=0, `wb_reg_write`=0.
- Pass-through: `reg_write`=1, `reg_addr`=3, `alu_res`=16'h1234, no memory op -> next cycle `wb_*`={1,3,16'h1234}, `hold` never 1.
- Store then load, WAIT_CYCLES=1:
  - Store 16'hBEEF to 18'h00100 -> `hold` high 2 cycles, `ram_rw` low 1 cycle with bus=16'hBEEF.
  - Load 18'h00100 into r5 (SRAM model) -> `wb_*`={1,5,16'hBEEF} in DONE.
- WAIT_CYCLES=3 load -> `hold` high exactly 4 cycles, `ram_oe` low exactly 3 cycles.
- Both `mem_read` and `mem_write` set -> SRAM write occurs, `wb_reg_write` stays 0.
- With `MEM_LED_MMIO_EN`:
  - Store 16'h00A5 to 18'h0BF00 -> `led_out`=16'h00A5 next cycle, `ram_en` stays 1, `hold`=0.
  - Load from 18'h0BF00 -> `wb_data`=16'h00A5.
